// File: rtl/fir_sample_uart_tx.sv
`default_nettype none
// ============================================================================
// fir_sample_uart_tx : buffers filtered 32-bit samples in a small FIFO and
// sends each as a 5-byte UART 8N1 frame (sync byte, then sample MSB first).
// Revision: 1.0
// ============================================================================
module fir_sample_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [31:0]                   in_data,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [7:0]    shift;
  logic [31:0]   frame;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic ovf_set;
  logic bit_done;

  assign empty    = (fifo_count == '0);
  assign full     = (fifo_count == COUNT_FULL);
  assign do_pop   = (state == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push  = in_valid && (!full || do_pop);
  assign ovf_set  = in_valid && full && !do_pop;
  assign bit_done = (cnt == BIT_LAST);

  always_comb begin
    count_nxt = fifo_count;
    if (do_push && !do_pop) begin
      count_nxt = fifo_count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nxt = fifo_count - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = (byte_idx < 3'd4) ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      frame      <= '0;
    end else begin
      state      <= state_nxt;
      fifo_count <= count_nxt;
      busy       <= (state_nxt != IDLE) || (count_nxt != '0);

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;

      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      cnt <= (state == IDLE || bit_done) ? '0 : cnt + 1'b1;

      // tx is loaded with the level of the state being entered, so it comes straight from a flop.
      case (state)
        IDLE: begin
          if (do_pop) begin
            frame    <= mem[rd_ptr];
            shift    <= SYNC_BYTE;
            byte_idx <= '0;
            tx       <= 1'b0;
          end else begin
            tx       <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_done && byte_idx < 3'd4) begin
            byte_idx <= byte_idx + 1'b1;
            shift    <= frame[31:24];
            frame    <= {frame[23:0], 8'h00};
            tx       <= 1'b0;
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_uart_tx.sv
`default_nettype none
// tb_fir_sample_uart_tx : directed and randomized checks against a
// transaction-level model (sample queue + frame timer + expected bit stream).
module tb_fir_sample_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 50 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        clr_overflow = 1'b0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  fir_sample_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .clr_overflow(clr_overflow),
    .tx(tx),
    .busy(busy),
    .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted samples, remaining frame time, expected line bits.
  logic [31:0] mq [$];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  dec_bytes [$];
  int          rem = 0;
  logic        m_ovf = 1'b0;
  logic [49:0] m_bits = '1;
  logic        m_pop;
  logic        m_full;
  logic [31:0] m_w;
  logic [7:0]  m_b;
  logic        dec_kill = 1'b1;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      exp_bytes.delete();
      rem      = 0;
      m_ovf    = 1'b0;
      dec_kill = 1'b1;
    end else begin
      m_pop  = (rem == 0) && (mq.size() > 0);
      m_full = (mq.size() == DEPTH);
      if (rem > 0) rem--;
      if (m_pop) begin
        m_w = mq.pop_front();
        rem = FRAME;
        for (int k = 0; k < 5; k++) begin
          m_b = (k == 0) ? 8'hA5 : m_w[31 - 8*(k-1) -: 8];
          exp_bytes.push_back(m_b);
          m_bits[10*k] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[10*k + 1 + i] = m_b[i];
          m_bits[10*k + 9] = 1'b1;
        end
      end
      if (in_valid && m_full && !m_pop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (in_valid && (!m_full || m_pop)) mq.push_back(in_data);
    end
  end

  // Cycle-by-cycle scoreboard of all outputs against the model.
  logic exp_tx;
  logic exp_busy;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_tx   = (rem > 0) ? m_bits[(FRAME - rem) / CPB] : 1'b1;
      exp_busy = (rem > 0) || (mq.size() > 0);
      vectors++;
      if (tx !== exp_tx || busy !== exp_busy || overflow !== m_ovf ||
          fifo_count !== 3'(mq.size())) begin
        errors++;
        $display("FAIL cycle %0d outputs: got tx=%b busy=%b ovf=%b count=%0d, want tx=%b busy=%b ovf=%b count=%0d",
                 cyc, tx, busy, overflow, fifo_count, exp_tx, exp_busy, m_ovf, mq.size());
      end
    end
  end

  // Line decoder: start-bit detect, mid-bit sampling.
  logic       dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_sh = '0;
  logic       tx_prev = 1'b1;
  always @(negedge clk) begin
    if (dec_kill) begin
      dec_active = 1'b0;
      dec_kill   = 1'b0;
      dec_bytes.delete();
    end else if (!dec_active) begin
      if (tx_prev === 1'b1 && tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= CPB + CPB/2 && dec_cnt < 9*CPB && ((dec_cnt - CPB - CPB/2) % CPB) == 0)
        dec_sh = {tx, dec_sh[7:1]};
      if (dec_cnt == 9*CPB + CPB/2) begin
        dec_bytes.push_back(dec_sh);
        dec_active = 1'b0;
      end
    end
    tx_prev = tx;
  end

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_tx_low(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      if (tx === 1'b0) begin c = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      if (busy === 1'b0) begin c = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    vectors++;
    if ({tx, busy, overflow, fifo_count} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_values got tx/busy/ovf/count=%b want 100000", {tx, busy, overflow, fifo_count});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tx, busy, overflow, fifo_count} !== 6'b100000) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 100000", {tx, busy, overflow, fifo_count});
    end
  endtask

  task automatic test_single();
    int w, f, e;
    logic [39:0] got;
    dec_bytes.delete();
    send(32'h12345678);
    w = cyc;
    wait_tx_low(10, f);
    vectors++;
    if (f != w + 1) begin
      errors++;
      $display("FAIL single_latency tx fell at %0d want %0d", f, w + 1);
    end
    wait_idle(FRAME + 20, e);
    vectors++;
    if (e - f != FRAME) begin
      errors++;
      $display("FAIL single_busy_fall busy fell %0d cycles after tx fall want %0d", e - f, FRAME);
    end
    repeat (2) @(negedge clk);
    got = '0;
    foreach (dec_bytes[k]) got = {got[31:0], dec_bytes[k]};
    vectors++;
    if (dec_bytes.size() != 5 || got !== 40'hA5_12_34_56_78 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_frame got %0d bytes %h ovf=%b want A512345678 ovf=0", dec_bytes.size(), got, overflow);
    end
  endtask

  task automatic test_negative();
    int f, e;
    logic [39:0] got;
    dec_bytes.delete();
    send(32'h80000001);
    wait_tx_low(10, f);
    wait_until(f + 10*CPB + CPB + CPB/2);
    vectors++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL neg_first_bit got %b want 0", tx);
    end
    wait_until(f + 10*CPB + 8*CPB + CPB/2);
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL neg_eighth_bit got %b want 1", tx);
    end
    wait_idle(FRAME + 20, e);
    repeat (2) @(negedge clk);
    got = '0;
    foreach (dec_bytes[k]) got = {got[31:0], dec_bytes[k]};
    vectors++;
    if (dec_bytes.size() != 5 || got !== 40'hA5_80_00_00_01) begin
      errors++;
      $display("FAIL neg_frame got %0d bytes %h want A580000001", dec_bytes.size(), got);
    end
  endtask

  task automatic test_burst_overflow();
    int e;
    logic [7:0] want;
    dec_bytes.delete();
    in_valid = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      in_data = 32'(v);
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL burst_overflow got ovf=%b count=%0d want ovf=1 count=4", overflow, fifo_count);
    end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_overflow got %b want 0", overflow);
    end
    wait_idle(6*FRAME, e);
    repeat (2) @(negedge clk);
    vectors++;
    if (dec_bytes.size() != 25) begin
      errors++;
      $display("FAIL burst_byte_count got %0d want 25", dec_bytes.size());
    end else begin
      for (int k = 0; k < 25; k++) begin
        want = (k % 5 == 0) ? 8'hA5 : (k % 5 == 4) ? 8'(k/5 + 1) : 8'h00;
        vectors++;
        if (dec_bytes[k] !== want) begin
          errors++;
          $display("FAIL burst_byte[%0d] got %h want %h", k, dec_bytes[k], want);
        end
      end
    end
  endtask

  task automatic test_push_pop_full();
    int f, e;
    logic [31:0] vals [6];
    logic [7:0] want;
    dec_bytes.delete();
    foreach (vals[k]) vals[k] = $urandom;
    send(vals[0]);
    wait_tx_low(10, f);
    for (int k = 1; k <= 4; k++) send(vals[k]);
    vectors++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL ppf_fill got count=%0d want 4", fifo_count);
    end
    wait_until(f + FRAME);
    send(vals[5]);
    vectors++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ppf_accept got count=%0d ovf=%b want count=4 ovf=0", fifo_count, overflow);
    end
    wait_idle(7*FRAME, e);
    repeat (2) @(negedge clk);
    vectors++;
    if (dec_bytes.size() != 30) begin
      errors++;
      $display("FAIL ppf_byte_count got %0d want 30", dec_bytes.size());
    end else begin
      for (int k = 0; k < 30; k++) begin
        want = (k % 5 == 0) ? 8'hA5 : vals[k/5][31 - 8*((k%5)-1) -: 8];
        if (dec_bytes[k] !== want) begin
          vectors++;
          errors++;
          $display("FAIL ppf_byte[%0d] got %h want %h", k, dec_bytes[k], want);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int f, e;
    logic [39:0] got;
    send($urandom);
    wait_tx_low(10, f);
    wait_until(f + 20*CPB + CPB + 6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset got tx=%b count=%0d busy=%b want 1 0 0", tx, fifo_count, busy);
    end
    @(negedge clk);
    send(32'hDEADBEEF);
    wait_idle(FRAME + 20, e);
    repeat (2) @(negedge clk);
    got = '0;
    foreach (dec_bytes[k]) got = {got[31:0], dec_bytes[k]};
    vectors++;
    if (dec_bytes.size() != 5 || got !== 40'hA5_DE_AD_BE_EF) begin
      errors++;
      $display("FAIL after_reset_frame got %0d bytes %h want A5DEADBEEF", dec_bytes.size(), got);
    end
  endtask

  task automatic test_back_to_back();
    int f1, f2, e;
    send($urandom);
    send($urandom);
    wait_tx_low(10, f1);
    wait_until(f1 + FRAME);
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_level got %b want 1", tx);
    end
    wait_tx_low(10, f2);
    vectors++;
    if (f2 - f1 != FRAME + 1) begin
      errors++;
      $display("FAIL b2b_gap got %0d cycles want %0d", f2 - f1, FRAME + 1);
    end
    wait_idle(2*FRAME + 20, e);
  endtask

  task automatic test_random();
    int e;
    repeat (2) @(negedge clk);
    dec_bytes.delete();
    exp_bytes.delete();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 250)) @(negedge clk);
      clr_overflow = ($urandom_range(0, 7) == 0);
      send($urandom);
      clr_overflow = 1'b0;
    end
    wait_idle((DEPTH + 2) * (FRAME + 1), e);
    repeat (2) @(negedge clk);
    vectors++;
    if (e < 0 || dec_bytes.size() != exp_bytes.size()) begin
      errors++;
      $display("FAIL random_byte_count got %0d want %0d (idle at %0d)", dec_bytes.size(), exp_bytes.size(), e);
    end else begin
      foreach (exp_bytes[k]) begin
        if (dec_bytes[k] !== exp_bytes[k]) begin
          vectors++;
          errors++;
          $display("FAIL random_byte[%0d] got %h want %h", k, dec_bytes[k], exp_bytes[k]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_negative();
    test_burst_overflow();
    test_push_pop_full();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_sample_uart_tx.md
# fir_sample_uart_tx

Output-side consumer for the 32-bit fixed-point low-pass filter. It captures filtered samples on a valid strobe, buffers them in a small FIFO, and serialises each one to the host as a 5-byte framed UART 8N1 stream. It sits between the filter output and the board's TX pin, and gives the host a way to read the filtered accelerometer channel.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, 4, sample FIFO depth in 32-bit words; must be a power of two, ≥ 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  high for one cycle per new filtered sample.
- in_data  in  32  signed filtered sample; sampled when in_valid=1.
- clr_overflow  in  1  synchronous clear of the overflow flag.
- tx  out  1  UART line; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- overflow  out  1  sticky flag: at least one sample was dropped.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words currently held.

## Operation
- Frame order: SYNC_BYTE, in_data[31:24], [23:16], [15:8], [7:0]. Each byte is sent as one start bit (0), data bits LSB first, then one stop bit (1). A frame is 50 bit-times.
- FIFO: write when in_valid=1 and the FIFO is not full. A pop occurs only when a frame starts (transmitter in IDLE and FIFO non-empty). The popped word goes into a 32-bit frame register.
- Push and pop in the same cycle: both take effect and fifo_count does not change. When the FIFO is full and a pop happens in that cycle, the push is accepted.
- Overflow: in_valid=1 while the FIFO is full and no pop happens that cycle. The sample is discarded, overflow is set, and the FIFO contents are unaffected. overflow clears on reset or clr_overflow=1. If a set and a clear happen in the same cycle, the set wins.
- State machine:
  - IDLE: tx=1. Go to START when the FIFO is non-empty; pop, set byte_idx=0 and load the shift register with SYNC_BYTE.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<4: increment byte_idx, load the next data byte, go to START;
    - otherwise go to IDLE.
- Back-to-back frames: when the FIFO is non-empty at the end of STOP of byte 4, IDLE lasts exactly one cycle before the next START.
- Counters: the bit-time counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state or bit transition. There is no fractional baud.
- Reset (rst_n=0 at an edge), at any point including mid-frame:
  - tx=1, state=IDLE, FIFO empty (fifo_count=0);
  - overflow=0, busy=0, all counters 0.
  - The partial frame is abandoned; no completion is sent.

## Timing
- All outputs are registered. tx must be glitch-free and come straight from a flop.
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0.
- Latency with the FIFO empty and the state IDLE:
  - write at edge N;
  - fifo_count=1 after edge N;
  - pop and START entry at edge N+1, so tx falls after edge N+1;
  - fifo_count returns to 0 after edge N+1.
- Frame duration: 50×CLKS_PER_BIT cycles, from tx falling to the end of the last stop bit.
- busy rises after the write edge. It falls after the edge that returns the machine to IDLE with the FIFO empty.
- Sustained throughput: one sample per 50×CLKS_PER_BIT+1 cycles. Faster input rates overflow once FIFO_DEPTH words are queued.

## Test plan
- Single sample: CLKS_PER_BIT=4. Send in_data=32'h12345678 with in_valid for one cycle. The decoded line must carry A5 12 34 56 78. tx falls 1 cycle after the write edge. busy drops 200 cycles after tx falls. overflow=0.
- Negative sample and bit order: send in_data=32'h80000001. The bytes must be A5 80 00 00 01. The first data bit of 0x80 must be 0 and its eighth bit 1.
- Burst and overflow: FIFO_DEPTH=4. Send 6 samples on consecutive cycles, values 1..6.
  - Expected frames: 1, 2, 3, 4, 5; sample 6 is dropped.
  - Why: sample 1 is popped one cycle after its write, so samples 2–5 fill the FIFO.
  - After sample 6: overflow=1 and fifo_count=4.
  - Pulse clr_overflow: overflow=0 on the next cycle.
- Simultaneous push and pop at full:
  - Setup: FIFO full, a frame ending.
  - Stimulus: assert in_valid on the pop cycle.
  - Expected: the sample is accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-frame: apply rst_n=0 for 1 cycle during DATA of byte 2.
  - tx must be 1 after the reset edge; fifo_count=0, busy=0.
  - A new sample 32'hDEADBEEF must then produce the clean frame A5 DE AD BE EF.
- Back-to-back timing: queue 2 samples. Exactly 1 idle-high cycle must separate the stop bit of frame 1 from the start bit of frame 2.
